// File: rtl/lcd_spi_tx_if.sv
// FIFO read handshake plus the LCD serial pins of the SPI LCD serialiser.
// The slave modport is the serialiser; the master modport is the FIFO/LCD side.
interface lcd_spi_tx_if #(
    parameter int WIDTH = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             lcd_sclk;
    logic             lcd_mosi;
    logic             lcd_dc;
    logic             lcd_cs_n;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, lcd_sclk, lcd_mosi, lcd_dc, lcd_cs_n, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, lcd_sclk, lcd_mosi, lcd_dc, lcd_cs_n, busy
    );
endinterface

// File: rtl/lcd_spi_tx.sv
// SPI mode-0 serialiser for 9-bit LCD command/data words popped from a FIFO.
// Bit WIDTH-1 drives D/C, bits 7:0 go out MSB first; CS stays low across back-to-back words.
module lcd_spi_tx #(
    parameter int CLK_DIV = 2,
    parameter int WIDTH   = 9
) (
    input  logic          clk,
    input  logic          rst,
    lcd_spi_tx_if.slave   bus
);
    localparam int            DW       = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    half_cnt_q, half_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          dc_q, dc_d;
    logic          cs_n_q, cs_n_d;
    logic          can_pop_s;

    // Pops only happen from IDLE/DONE; rst masks the pop so nothing is lost during reset.
    assign can_pop_s    = (state_q == IDLE) || (state_q == DONE);
    assign bus.in_ready = ~rst & bus.in_valid & can_pop_s;
    assign bus.busy     = (state_q != IDLE);
    assign bus.lcd_sclk = sclk_q;
    assign bus.lcd_mosi = mosi_q;
    assign bus.lcd_dc   = dc_q;
    assign bus.lcd_cs_n = cs_n_q;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            half_cnt_q <= 4'd0;
            shreg_q    <= 8'd0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            dc_q       <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            half_cnt_q <= half_cnt_d;
            shreg_q    <= shreg_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            dc_q       <= dc_d;
            cs_n_q     <= cs_n_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        half_cnt_d = half_cnt_q;
        shreg_d    = shreg_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        dc_d       = dc_q;
        cs_n_d     = cs_n_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end

            // The FIFO presents the popped word one cycle after the pop.
            FETCH: begin
                shreg_d    = bus.in_data[7:0];
                dc_d       = bus.in_data[WIDTH-1];
                mosi_d     = bus.in_data[7];
                cs_n_d     = 1'b0;
                sclk_d     = 1'b0;
                div_cnt_d  = '0;
                half_cnt_d = 4'd0;
                state_d    = SHIFT;
            end

            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d  = '0;
                    sclk_d     = ~sclk_q;
                    half_cnt_d = half_cnt_q + 4'd1;
                    // Data only moves on falling edges; the last falling edge ends the byte.
                    if (sclk_q && (half_cnt_q == 4'd15)) begin
                        state_d = DONE;
                    end else if (sclk_q) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        mosi_d  = shreg_q[6];
                    end else begin
                        shreg_d = shreg_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end

            DONE: begin
                if (bus.in_valid) begin
                    state_d = FETCH;
                end else begin
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
